// File: rtl/arm_seq_ctrl.sv
// arm_seq_ctrl -- instruction sequencer for the 16-bit ARM-style datapath.
// Owns PC, instruction register and retired-instruction counter; fetches
// over a req/ack handshake and sequences FETCH -> EXEC1 [-> EXEC2] phases.
// Optional build macro: ARM_SEQ_STEP_EN enables single-step operation, where
// each fetch waits for a latched `step` pulse.

module arm_seq_ctrl #(
  parameter int              AW       = 8,
  parameter logic [AW-1:0]   RESET_PC = {AW{1'b0}}
) (
  input  logic          clk,
  input  logic          reset,
  output logic          imem_req,
  output logic [AW-1:0] imem_addr,
  input  logic          imem_ack,
  input  logic [15:0]   imem_rdata,
  output logic          dmem_req,
  input  logic          dmem_ack,
  output logic [15:0]   inst,
  output logic [2:0]    state,
  output logic [AW-1:0] pc,
  output logic          halted,
  output logic [15:0]   retired,
  input  logic          step
);

  // State encoding doubles as the one-hot phase bus driven to the datapath.
  typedef enum logic [2:0] {
    ST_HALT  = 3'b000,
    ST_FETCH = 3'b001,
    ST_EXEC1 = 3'b010,
    ST_EXEC2 = 3'b100
  } state_e;

  // Control-flow classes; ALU ops, moves and NOPs all simply fall through.
  typedef enum logic [1:0] {
    OP_SEQ  = 2'd0,
    OP_LDR  = 2'd1,
    OP_JMP  = 2'd2,
    OP_HALT = 2'd3
  } op_class_e;

  localparam logic [AW-1:0] PC_INC  = {{(AW-1){1'b0}}, 1'b1};
  localparam logic [15:0]   RET_INC = 16'h0001;

  // Classify an opcode nibble by how it affects sequencing.
  function automatic op_class_e decode_op(input logic [3:0] opc);
    op_class_e cls;
    case (opc)
      4'b1110: cls = OP_LDR;
      4'b0000: cls = OP_JMP;
      4'b0001: cls = OP_HALT;
      default: cls = OP_SEQ;
    endcase
    return cls;
  endfunction

  state_e        state_q, state_d;
  logic [AW-1:0] pc_q, pc_d;
  logic [15:0]   inst_q, inst_d;
  logic [15:0]   retired_q, retired_d;
  logic          imem_req_s;
  logic          fetch_ack_s;
  op_class_e     op_s;

  assign op_s        = decode_op(inst_q[15:12]);
  assign fetch_ack_s = imem_req_s & imem_ack;

`ifdef ARM_SEQ_STEP_EN
  logic step_armed_q, step_armed_d;

  assign imem_req_s = (state_q == ST_FETCH) && step_armed_q;

  // Latch a step pulse; the fetch ack consumes it, extra pulses are absorbed.
  always_comb begin
    step_armed_d = step_armed_q;
    if (fetch_ack_s) begin
      step_armed_d = 1'b0;
    end else if (step) begin
      step_armed_d = 1'b1;
    end else begin
      step_armed_d = step_armed_q;
    end
  end

  // Step latch register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      step_armed_q <= 1'b0;
    end else begin
      step_armed_q <= step_armed_d;
    end
  end
`else
  logic unused_step_s;

  assign unused_step_s = step;
  assign imem_req_s    = (state_q == ST_FETCH);
`endif

  // Next-state, PC, instruction register and retirement counter.
  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    inst_d    = inst_q;
    retired_d = retired_q;
    case (state_q)
      ST_FETCH: begin
        if (fetch_ack_s) begin
          inst_d  = imem_rdata;
          pc_d    = pc_q + PC_INC;
          state_d = ST_EXEC1;
        end else begin
          state_d = ST_FETCH;
        end
      end
      ST_EXEC1: begin
        case (op_s)
          OP_LDR: begin
            state_d = ST_EXEC2;
          end
          OP_JMP: begin
            pc_d      = inst_q[AW-1:0];
            retired_d = retired_q + RET_INC;
            state_d   = ST_FETCH;
          end
          OP_HALT: begin
            retired_d = retired_q + RET_INC;
            state_d   = ST_HALT;
          end
          default: begin
            retired_d = retired_q + RET_INC;
            state_d   = ST_FETCH;
          end
        endcase
      end
      ST_EXEC2: begin
        // The datapath writes every EXEC2 cycle; the ack cycle's write is final.
        if (dmem_ack) begin
          retired_d = retired_q + RET_INC;
          state_d   = ST_FETCH;
        end else begin
          state_d = ST_EXEC2;
        end
      end
      ST_HALT: begin
        state_d = ST_HALT;
      end
      default: begin
        // Illegal encoding: restart the fetch cycle rather than lock up.
        state_d = ST_FETCH;
      end
    endcase
  end

  // Sequencer state registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= ST_FETCH;
      pc_q      <= RESET_PC;
      inst_q    <= 16'h0000;
      retired_q <= 16'h0000;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      inst_q    <= inst_d;
      retired_q <= retired_d;
    end
  end

  assign imem_req  = imem_req_s;
  assign imem_addr = pc_q;
  assign dmem_req  = (state_q == ST_EXEC2);
  assign halted    = (state_q == ST_HALT);
  assign inst      = inst_q;
  assign state     = state_q;
  assign pc        = pc_q;
  assign retired   = retired_q;

endmodule

// File: tb/tb_arm_seq_ctrl.sv
// Self-checking bench for arm_seq_ctrl: directed scenarios plus a randomized
// program run checked against an instruction-level reference model.

module tb_arm_seq_ctrl;

  logic        clk;
  logic        reset;
  logic        imem_req;
  logic [7:0]  imem_addr;
  logic        imem_ack;
  logic [15:0] imem_rdata;
  logic        dmem_req;
  logic        dmem_ack;
  logic [15:0] inst;
  logic [2:0]  state;
  logic [7:0]  pc;
  logic        halted;
  logic [15:0] retired;
  logic        step;

  int n_checks;
  int n_fail;

  typedef struct packed {
    logic [2:0]  st;
    logic [7:0]  pc;
    logic [15:0] inst;
    logic [15:0] ret;
    logic        ia;
    logic [15:0] rd;
    logic        da;
  } cyc_t;

  arm_seq_ctrl #(.AW(8), .RESET_PC(8'h00)) dut (
    .clk        (clk),
    .reset      (reset),
    .imem_req   (imem_req),
    .imem_addr  (imem_addr),
    .imem_ack   (imem_ack),
    .imem_rdata (imem_rdata),
    .dmem_req   (dmem_req),
    .dmem_ack   (dmem_ack),
    .inst       (inst),
    .state      (state),
    .pc         (pc),
    .halted     (halted),
    .retired    (retired),
    .step       (step)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Apply inputs for one cycle, land on the following falling edge.
  task automatic drive(input logic ia, input logic [15:0] rd, input logic da);
    imem_ack   = ia;
    imem_rdata = rd;
    dmem_ack   = da;
    @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1; imem_ack = 1'b0; dmem_ack = 1'b0; step = 1'b0;
    @(negedge clk);
    reset = 1'b0;
  endtask

  function automatic cyc_t mk(input logic [2:0] st, input logic [7:0] p,
                              input logic [15:0] i, input logic [15:0] r,
                              input logic ia, input logic [15:0] rd, input logic da);
    cyc_t c;
    c.st = st; c.pc = p; c.inst = i; c.ret = r; c.ia = ia; c.rd = rd; c.da = da;
    return c;
  endfunction

  task automatic test_reset();
    logic exp_req;
`ifdef ARM_SEQ_STEP_EN
    exp_req = 1'b0;
`else
    exp_req = 1'b1;
`endif
    reset = 1'b1; imem_ack = 1'b1; dmem_ack = 1'b1; step = 1'b0; imem_rdata = 16'hE123;
    #22;
    n_checks++;
    if (pc !== 8'h00 || inst !== 16'h0000 || state !== 3'b001 || halted !== 1'b0 ||
        retired !== 16'h0000 || imem_req !== exp_req || dmem_req !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_values: got pc=%h inst=%h state=%b halted=%b ret=%h ireq=%b dreq=%b, expected pc=00 inst=0000 state=001 halted=0 ret=0000 ireq=%b dreq=0",
               pc, inst, state, halted, retired, imem_req, dmem_req, exp_req);
    end
    @(negedge clk);
    reset = 1'b0; imem_ack = 1'b0; dmem_ack = 1'b0;
  endtask

  task automatic test_alu_zero_wait();
    do_reset();
    drive(1'b1, 16'h8123, 1'b0);
    n_checks++;
    if (state !== 3'b010 || pc !== 8'h01 || inst !== 16'h8123 || retired !== 16'h0000) begin
      n_fail++;
      $display("FAIL alu_exec1: got state=%b pc=%h inst=%h ret=%h, expected 010 01 8123 0000", state, pc, inst, retired);
    end
    drive(1'b0, 16'h0000, 1'b0);
    n_checks++;
    if (state !== 3'b001 || pc !== 8'h01 || retired !== 16'h0001 || imem_addr !== 8'h01) begin
      n_fail++;
      $display("FAIL alu_done: got state=%b pc=%h ret=%h addr=%h, expected 001 01 0001 01", state, pc, retired, imem_addr);
    end
  endtask

  task automatic test_ldr_wait();
    do_reset();
    drive(1'b1, 16'hE012, 1'b0);
    drive(1'b0, 16'h0000, 1'b0);
    for (int i = 0; i < 4; i++) begin
      n_checks++;
      if (state !== 3'b100 || dmem_req !== 1'b1 || imem_req !== 1'b0 || retired !== 16'h0000) begin
        n_fail++;
        $display("FAIL ldr_exec2_cycle%0d: got state=%b dreq=%b ireq=%b ret=%h, expected 100 1 0 0000", i, state, dmem_req, imem_req, retired);
      end
      drive(1'b0, 16'h0000, (i == 3) ? 1'b1 : 1'b0);
    end
    n_checks++;
    if (state !== 3'b001 || retired !== 16'h0001 || pc !== 8'h01 || dmem_req !== 1'b0) begin
      n_fail++;
      $display("FAIL ldr_done: got state=%b ret=%h pc=%h dreq=%b, expected 001 0001 01 0", state, retired, pc, dmem_req);
    end
  endtask

  task automatic test_jump_wrap();
    do_reset();
    drive(1'b1, 16'h0005, 1'b0);
    drive(1'b0, 16'h0000, 1'b0);
    drive(1'b1, 16'h0F42, 1'b0);
    n_checks++;
    if (pc !== 8'h06 || state !== 3'b010) begin
      n_fail++;
      $display("FAIL jmp_exec1: got pc=%h state=%b, expected 06 010", pc, state);
    end
    drive(1'b0, 16'h0000, 1'b0);
    n_checks++;
    if (imem_addr !== 8'h42 || retired !== 16'h0002 || state !== 3'b001) begin
      n_fail++;
      $display("FAIL jmp_target: got addr=%h ret=%h state=%b, expected 42 0002 001", imem_addr, retired, state);
    end
    drive(1'b1, 16'h00FF, 1'b0);
    drive(1'b0, 16'h0000, 1'b0);
    drive(1'b1, 16'h4000, 1'b0);
    n_checks++;
    if (pc !== 8'h00 || inst !== 16'h4000) begin
      n_fail++;
      $display("FAIL pc_wrap: got pc=%h inst=%h, expected 00 4000", pc, inst);
    end
    drive(1'b0, 16'h0000, 1'b0);
    for (int k = 0; k < 3; k++) begin
      drive(1'b1, 16'h0000, 1'b0);
      drive(1'b0, 16'h0000, 1'b0);
      n_checks++;
      if (pc !== 8'h00 || state !== 3'b001 || retired !== 16'(5 + k)) begin
        n_fail++;
        $display("FAIL jmp_self_%0d: got pc=%h state=%b ret=%h, expected 00 001 %h", k, pc, state, retired, 16'(5 + k));
      end
    end
  endtask

  task automatic test_halt();
    do_reset();
    drive(1'b1, 16'h1000, 1'b0);
    drive(1'b0, 16'h0000, 1'b0);
    n_checks++;
    if (state !== 3'b000 || halted !== 1'b1 || retired !== 16'h0001 || pc !== 8'h01) begin
      n_fail++;
      $display("FAIL halt_entry: got state=%b halted=%b ret=%h pc=%h, expected 000 1 0001 01", state, halted, retired, pc);
    end
    for (int i = 0; i < 10; i++) begin
      drive(i[0], 16'($urandom), ~i[0]);
      n_checks++;
      if (imem_req !== 1'b0 || dmem_req !== 1'b0 || state !== 3'b000 || pc !== 8'h01 ||
          inst !== 16'h1000 || retired !== 16'h0001) begin
        n_fail++;
        $display("FAIL halt_hold_%0d: got ireq=%b dreq=%b state=%b pc=%h inst=%h ret=%h", i, imem_req, dmem_req, state, pc, inst, retired);
      end
    end
    do_reset();
    n_checks++;
    if (pc !== 8'h00 || state !== 3'b001 || halted !== 1'b0 || retired !== 16'h0000) begin
      n_fail++;
      $display("FAIL halt_reset: got pc=%h state=%b halted=%b ret=%h, expected 00 001 0 0000", pc, state, halted, retired);
    end
  endtask

  task automatic test_reset_in_exec2();
    do_reset();
    drive(1'b1, 16'hA001, 1'b0);
    drive(1'b0, 16'h0000, 1'b0);
    drive(1'b1, 16'hE055, 1'b0);
    drive(1'b0, 16'h0000, 1'b0);
    drive(1'b0, 16'h0000, 1'b0);
    n_checks++;
    if (state !== 3'b100 || dmem_req !== 1'b1 || retired !== 16'h0001 || pc !== 8'h02) begin
      n_fail++;
      $display("FAIL exec2_before_reset: got state=%b dreq=%b ret=%h pc=%h, expected 100 1 0001 02", state, dmem_req, retired, pc);
    end
    reset = 1'b1;
    #1;
    n_checks++;
    if (pc !== 8'h00 || state !== 3'b001 || retired !== 16'h0000 || dmem_req !== 1'b0 || inst !== 16'h0000) begin
      n_fail++;
      $display("FAIL reset_mid_exec2: got pc=%h state=%b ret=%h dreq=%b inst=%h, expected 00 001 0000 0 0000", pc, state, retired, dmem_req, inst);
    end
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_random(input int nins);
    cyc_t        q[$];
    cyc_t        c;
    logic [7:0]  mpc;
    logic [15:0] minst, mret, w;
    logic [3:0]  nib;
    int          r, f, d, errs;
    mpc = 8'h00; minst = 16'h0000; mret = 16'h0000; errs = 0;
    for (int k = 0; k < nins; k++) begin
      r = $urandom_range(0, 9);
      case (r)
        3, 4:    nib = 4'hE;
        5:       nib = 4'h0;
        6:       nib = 4'($urandom_range(2, 3));
        7, 8:    nib = 4'($urandom_range(4, 7));
        9:       nib = 4'hF;
        default: nib = 4'($urandom_range(8, 13));
      endcase
      if (k == nins - 1) nib = 4'h1;
      w = {nib, 12'($urandom)};
      f = $urandom_range(0, 2);
      for (int j = 0; j < f; j++)
        q.push_back(mk(3'b001, mpc, minst, mret, 1'b0, 16'($urandom), 1'($urandom)));
      q.push_back(mk(3'b001, mpc, minst, mret, 1'b1, w, 1'($urandom)));
      minst = w;
      mpc   = mpc + 8'h01;
      q.push_back(mk(3'b010, mpc, minst, mret, 1'($urandom), 16'($urandom), 1'($urandom)));
      if (nib == 4'hE) begin
        d = $urandom_range(0, 3);
        for (int j = 0; j < d; j++)
          q.push_back(mk(3'b100, mpc, minst, mret, 1'($urandom), 16'($urandom), 1'b0));
        q.push_back(mk(3'b100, mpc, minst, mret, 1'($urandom), 16'($urandom), 1'b1));
        mret = mret + 16'h0001;
      end else if (nib == 4'h0) begin
        mret = mret + 16'h0001;
        mpc  = w[7:0];
      end else if (nib == 4'h1) begin
        mret = mret + 16'h0001;
        for (int j = 0; j < 6; j++)
          q.push_back(mk(3'b000, mpc, minst, mret, 1'($urandom), 16'($urandom), 1'($urandom)));
      end else begin
        mret = mret + 16'h0001;
      end
    end
    do_reset();
    foreach (q[i]) begin
      c = q[i];
      n_checks++;
      if (state !== c.st || pc !== c.pc || imem_addr !== c.pc || inst !== c.inst ||
          retired !== c.ret || imem_req !== (c.st == 3'b001) ||
          dmem_req !== (c.st == 3'b100) || halted !== (c.st == 3'b000)) begin
        n_fail++;
        errs++;
        $display("FAIL random_cycle_%0d: got state=%b pc=%h addr=%h inst=%h ret=%h ireq=%b dreq=%b halted=%b, expected state=%b pc=%h inst=%h ret=%h",
                 i, state, pc, imem_addr, inst, retired, imem_req, dmem_req, halted, c.st, c.pc, c.inst, c.ret);
      end
      if (errs >= 10) break;
      drive(c.ia, c.rd, c.da);
    end
    imem_ack = 1'b0;
    dmem_ack = 1'b0;
  endtask

  task automatic test_step();
    do_reset();
    for (int i = 0; i < 20; i++) begin
      drive(1'($urandom), 16'h8000, 1'b0);
      n_checks++;
      if (imem_req !== 1'b0 || state !== 3'b001 || pc !== 8'h00) begin
        n_fail++;
        $display("FAIL step_idle_%0d: got ireq=%b state=%b pc=%h, expected 0 001 00", i, imem_req, state, pc);
      end
    end
    for (int p = 0; p < 3; p++) begin
      step = 1'b1;
      drive(1'b0, 16'h0000, 1'b0);
      step = 1'b0;
      n_checks++;
      if (imem_req !== 1'b1) begin
        n_fail++;
        $display("FAIL step_arm_%0d: got ireq=%b expected 1", p, imem_req);
      end
      if (p == 0) begin
        step = 1'b1;
        drive(1'b0, 16'h0000, 1'b0);
        step = 1'b0;
      end
      drive(1'b1, 16'(16'h8000 + p), 1'b0);
      drive(1'b0, 16'h0000, 1'b0);
      for (int i = 0; i < 3; i++) begin
        drive(1'b1, 16'h9999, 1'b0);
        n_checks++;
        if (imem_req !== 1'b0 || retired !== 16'(p + 1) || state !== 3'b001) begin
          n_fail++;
          $display("FAIL step_retire_%0d_%0d: got ireq=%b ret=%h state=%b, expected 0 %h 001", p, i, imem_req, retired, state, 16'(p + 1));
        end
      end
    end
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    step     = 1'b0;
    imem_ack = 1'b0;
    dmem_ack = 1'b0;
    imem_rdata = 16'h0000;
    test_reset();
`ifdef ARM_SEQ_STEP_EN
    test_step();
`else
    test_alu_zero_wait();
    test_ldr_wait();
    test_jump_wrap();
    test_halt();
    test_reset_in_exec2();
    test_random(150);
    test_random(150);
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
